// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: default widths and the branch target buffer
// entry layout used by the fetch-stage branch predictor.
package pipeline_pkg;

  localparam int DATA_WIDTH = 64;
  localparam int BP_ENTRIES = 64;
  localparam int BP_TAG_W   = 16;
  localparam int BP_CNT_W   = 2;

  // One BTB entry at the default widths.
  typedef struct packed {
    logic                  valid;
    logic [BP_TAG_W-1:0]   tag;
    logic [DATA_WIDTH-1:0] target;
    logic [BP_CNT_W-1:0]   counter;
  } bp_entry_t;

endpackage

// File: rtl/bp_sat_counter.sv
// Next-state logic for one saturating direction counter. The register lives
// in the caller; this block only computes what the counter becomes.
module bp_sat_counter import pipeline_pkg::*; #(
  parameter int CNT_W = BP_CNT_W
) (
  input  logic [CNT_W-1:0] cnt_q,
  input  logic             inc,
  input  logic             dec,
  input  logic             load_max,
  input  logic             load_val,
  input  logic [CNT_W-1:0] value,
  output logic [CNT_W-1:0] cnt_d
);

  // Loads take priority over counting; counting clamps at all-ones and zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_max) begin
      cnt_d = '1;
    end else if (load_val) begin
      cnt_d = value;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with per-entry saturating counters.
// Lookup is combinational from the fetch PC; training comes from EX.
module branch_predictor import pipeline_pkg::*; #(
  parameter int DATA_WIDTH = pipeline_pkg::DATA_WIDTH,
  parameter int ENTRIES    = BP_ENTRIES,
  parameter int TAG_W      = BP_TAG_W,
  parameter int CNT_W      = BP_CNT_W
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DATA_WIDTH-1:0] pc_i,
  output logic                  pred_hit_o,
  output logic                  pred_taken_o,
  output logic [DATA_WIDTH-1:0] pred_pc_o,
  input  logic                  upd_valid_i,
  input  logic [DATA_WIDTH-1:0] upd_pc_i,
  input  logic                  upd_is_jump_i,
  input  logic                  upd_taken_i,
  input  logic [DATA_WIDTH-1:0] upd_target_i,
  input  logic                  upd_mispredict_i,
  input  logic                  flush_all_i,
  output logic [31:0]           mispredict_cnt_o
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_LO = IDX_W + 2;
  localparam int TAG_HI = IDX_W + TAG_W + 1;
  localparam logic [CNT_W-1:0] CNT_WT  = CNT_W'(1 << (CNT_W - 1));
  localparam logic [CNT_W-1:0] CNT_WNT = CNT_W'((1 << (CNT_W - 1)) - 1);

  // Same layout as bp_entry_t, but sized by this instance's parameters.
  typedef struct packed {
    logic                  valid;
    logic [TAG_W-1:0]      tag;
    logic [DATA_WIDTH-1:0] target;
    logic [CNT_W-1:0]      counter;
  } entry_t;

  entry_t bp_table [ENTRIES];

  logic [IDX_W-1:0] look_idx, upd_idx;
  logic [TAG_W-1:0] look_tag, upd_tag;
  entry_t           look_entry, upd_entry, new_entry;
  logic             upd_hit, wr_en;
  logic             cnt_inc, cnt_dec, cnt_load_max, cnt_load_val;
  logic [CNT_W-1:0] cnt_next;
  logic [31:0]      miss_count, miss_count_next;

  assign look_idx = pc_i[IDX_W+1:2];
  assign look_tag = pc_i[TAG_HI:TAG_LO];
  assign upd_idx  = upd_pc_i[IDX_W+1:2];
  assign upd_tag  = upd_pc_i[TAG_HI:TAG_LO];

  // Instruction-alignment bits and PC bits above the tag take no part in
  // indexing or tagging.
  logic unused_pc_bits;
  if (TAG_HI + 1 < DATA_WIDTH) begin : g_upper
    assign unused_pc_bits = &{1'b0, pc_i[1:0], upd_pc_i[1:0],
                              pc_i[DATA_WIDTH-1:TAG_HI+1],
                              upd_pc_i[DATA_WIDTH-1:TAG_HI+1]};
  end else begin : g_no_upper
    assign unused_pc_bits = &{1'b0, pc_i[1:0], upd_pc_i[1:0]};
  end

  // Fetch lookup: predict the stored target only on a hit with a taken counter.
  always_comb begin
    look_entry   = bp_table[look_idx];
    pred_hit_o   = look_entry.valid && (look_entry.tag == look_tag);
    pred_taken_o = pred_hit_o && look_entry.counter[CNT_W-1];
    pred_pc_o    = pred_taken_o ? look_entry.target : pc_i + DATA_WIDTH'(4);
  end

  // Decide how the resolved instruction trains its entry.
  always_comb begin
    upd_entry    = bp_table[upd_idx];
    upd_hit      = upd_entry.valid && (upd_entry.tag == upd_tag);
    cnt_inc      = 1'b0;
    cnt_dec      = 1'b0;
    cnt_load_max = 1'b0;
    cnt_load_val = 1'b0;
    wr_en        = 1'b0;
    if (upd_valid_i) begin
      if (upd_hit) begin
        wr_en        = 1'b1;
        cnt_load_max = upd_is_jump_i;
        cnt_inc      = !upd_is_jump_i && upd_taken_i;
        cnt_dec      = !upd_is_jump_i && !upd_taken_i;
      end else if (upd_taken_i) begin
        wr_en        = 1'b1;
        cnt_load_max = upd_is_jump_i;
        cnt_load_val = !upd_is_jump_i;
      end
    end
  end

  bp_sat_counter #(.CNT_W(CNT_W)) u_counter (
    .cnt_q    (upd_entry.counter),
    .inc      (cnt_inc),
    .dec      (cnt_dec),
    .load_max (cnt_load_max),
    .load_val (cnt_load_val),
    .value    (CNT_WT),
    .cnt_d    (cnt_next)
  );

  // Build the entry written back: a miss allocates, a hit keeps its tag.
  always_comb begin
    new_entry         = upd_entry;
    new_entry.counter = cnt_next;
    if (!upd_hit) begin
      new_entry.valid = 1'b1;
      new_entry.tag   = upd_tag;
    end
    if (upd_is_jump_i || upd_taken_i) begin
      new_entry.target = upd_target_i;
    end
  end

  // Table storage; a flush issued later in the block overrides any allocation.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < ENTRIES; i++) begin
        bp_table[i] <= '{valid: 1'b0, tag: '0, target: '0, counter: CNT_WNT};
      end
    end else begin
      if (wr_en) begin
        bp_table[upd_idx] <= new_entry;
      end
      if (flush_all_i) begin
        for (int i = 0; i < ENTRIES; i++) begin
          bp_table[i].valid <= 1'b0;
        end
      end
    end
  end

  assign miss_count_next = (upd_valid_i && upd_mispredict_i && (miss_count != '1))
                         ? miss_count + 32'd1 : miss_count;

  // Saturating mispredict statistics counter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      miss_count <= '0;
    end else begin
      miss_count <= miss_count_next;
    end
  end

  assign mispredict_cnt_o = miss_count;

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor at default parameters.
module tb_branch_predictor;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [63:0] pc_i;
  logic        pred_hit_o, pred_taken_o;
  logic [63:0] pred_pc_o;
  logic        upd_valid_i, upd_is_jump_i, upd_taken_i, upd_mispredict_i, flush_all_i;
  logic [63:0] upd_pc_i, upd_target_i;
  logic [31:0] mispredict_cnt_o;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    string       tag;
    logic        hit;
    logic        taken;
    logic [63:0] npc;
  } exp_t;

  exp_t exp_q[$];

  branch_predictor dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .pc_i             (pc_i),
    .pred_hit_o       (pred_hit_o),
    .pred_taken_o     (pred_taken_o),
    .pred_pc_o        (pred_pc_o),
    .upd_valid_i      (upd_valid_i),
    .upd_pc_i         (upd_pc_i),
    .upd_is_jump_i    (upd_is_jump_i),
    .upd_taken_i      (upd_taken_i),
    .upd_target_i     (upd_target_i),
    .upd_mispredict_i (upd_mispredict_i),
    .flush_all_i      (flush_all_i),
    .mispredict_cnt_o (mispredict_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Pop the oldest expectation and compare it with the live lookup outputs.
  task automatic collectOutput();
    exp_t e;
    if (exp_q.size() == 0) begin
      checkOutput("scoreboard_empty", 64'd1, 64'd0);
    end else begin
      e = exp_q.pop_front();
      checkOutput({e.tag, "_hit"}, {63'd0, pred_hit_o}, {63'd0, e.hit});
      checkOutput({e.tag, "_taken"}, {63'd0, pred_taken_o}, {63'd0, e.taken});
      checkOutput({e.tag, "_pc"}, pred_pc_o, e.npc);
    end
  endtask

  task automatic applyStimulus(input string tag, input logic [63:0] pc,
                               input bit hit, input bit taken, input logic [63:0] npc);
    pc_i = pc;
    exp_q.push_back('{tag: tag, hit: hit, taken: taken, npc: npc});
    #1;
    collectOutput();
  endtask

  task automatic doUpdate(input logic [63:0] pc, input bit jump, input bit taken,
                          input logic [63:0] target, input bit mis, input bit flush);
    @(negedge clk_i);
    upd_valid_i      = 1'b1;
    upd_pc_i         = pc;
    upd_is_jump_i    = jump;
    upd_taken_i      = taken;
    upd_target_i     = target;
    upd_mispredict_i = mis;
    flush_all_i      = flush;
    @(posedge clk_i);
    #1;
    upd_valid_i      = 1'b0;
    upd_mispredict_i = 1'b0;
    flush_all_i      = 1'b0;
  endtask

  localparam logic [63:0] PC_B   = 64'h8000_0010;
  localparam logic [63:0] PC_A   = 64'h8000_0110;
  localparam logic [63:0] PC_J   = 64'h8000_0020;
  localparam logic [63:0] PC_N   = 64'h8000_0040;

  initial begin
    rst_i = 1'b1;
    pc_i = 64'h8000_0000;
    upd_valid_i = 1'b0; upd_pc_i = '0; upd_is_jump_i = 1'b0; upd_taken_i = 1'b0;
    upd_target_i = '0; upd_mispredict_i = 1'b0; flush_all_i = 1'b0;

    repeat (2) @(negedge clk_i);
    applyStimulus("in_reset", 64'h8000_0000, 0, 0, 64'h8000_0004);
    rst_i = 1'b0;
    @(negedge clk_i);
    applyStimulus("after_reset", 64'h8000_0000, 0, 0, 64'h8000_0004);
    checkOutput("cnt_reset", {32'd0, mispredict_cnt_o}, 64'd0);

    // Allocation of a taken branch; the same-cycle lookup still sees the miss.
    @(negedge clk_i);
    upd_valid_i = 1'b1; upd_pc_i = PC_B; upd_is_jump_i = 1'b0; upd_taken_i = 1'b1;
    upd_target_i = 64'h8000_0100;
    applyStimulus("same_cycle", PC_B, 0, 0, 64'h8000_0014);
    @(posedge clk_i);
    #1;
    upd_valid_i = 1'b0;
    applyStimulus("alloc", PC_B, 1, 1, 64'h8000_0100);

    // Counter training: 10 -> 01 -> 00 -> 00 -> 01 -> 10 -> 11 -> 11 -> 10 -> 01.
    doUpdate(PC_B, 0, 0, 64'h8000_0300, 0, 0);
    applyStimulus("nt1", PC_B, 1, 0, 64'h8000_0014);
    doUpdate(PC_B, 0, 0, 64'h8000_0300, 0, 0);
    applyStimulus("nt2", PC_B, 1, 0, 64'h8000_0014);
    doUpdate(PC_B, 0, 0, 64'h8000_0300, 0, 0);
    applyStimulus("nt3_floor", PC_B, 1, 0, 64'h8000_0014);
    doUpdate(PC_B, 0, 1, 64'h8000_0100, 0, 0);
    applyStimulus("t1", PC_B, 1, 0, 64'h8000_0014);
    doUpdate(PC_B, 0, 1, 64'h8000_0100, 0, 0);
    applyStimulus("t2", PC_B, 1, 1, 64'h8000_0100);
    doUpdate(PC_B, 0, 1, 64'h8000_0100, 0, 0);
    applyStimulus("t3", PC_B, 1, 1, 64'h8000_0100);
    doUpdate(PC_B, 0, 1, 64'h8000_0200, 0, 0);
    applyStimulus("t4_ceiling", PC_B, 1, 1, 64'h8000_0200);
    doUpdate(PC_B, 0, 0, 64'h8000_0300, 0, 0);
    applyStimulus("nt_keep_tgt", PC_B, 1, 1, 64'h8000_0200);
    doUpdate(PC_B, 0, 0, 64'h8000_0300, 0, 0);
    applyStimulus("nt_to_01", PC_B, 1, 0, 64'h8000_0014);

    // Aliasing: same index, different tag replaces the entry.
    doUpdate(PC_A, 0, 1, 64'h8000_0500, 0, 0);
    applyStimulus("alias_old", PC_B, 0, 0, 64'h8000_0014);
    applyStimulus("alias_new", PC_A, 1, 1, 64'h8000_0500);
    doUpdate(PC_B, 0, 0, 64'h8000_0600, 0, 0);
    applyStimulus("miss_nt_nochg", PC_A, 1, 1, 64'h8000_0500);

    // Jump with simultaneous flush is discarded; without flush it allocates at MAX.
    doUpdate(PC_J, 1, 1, 64'h8000_0400, 1, 1);
    applyStimulus("flush_jal", PC_J, 0, 0, 64'h8000_0024);
    applyStimulus("flush_other", PC_A, 0, 0, 64'h8000_0114);
    doUpdate(PC_J, 1, 1, 64'h8000_0400, 1, 0);
    applyStimulus("jal_alloc", PC_J, 1, 1, 64'h8000_0400);
    checkOutput("cnt_two", {32'd0, mispredict_cnt_o}, 64'd2);
    doUpdate(PC_J, 0, 0, 64'h0, 0, 0);
    applyStimulus("jal_nt1", PC_J, 1, 1, 64'h8000_0400);
    doUpdate(PC_J, 0, 0, 64'h0, 0, 0);
    applyStimulus("jal_nt2", PC_J, 1, 0, 64'h8000_0024);
    doUpdate(PC_J, 1, 1, 64'h8000_0800, 0, 0);
    applyStimulus("jalr_hit", PC_J, 1, 1, 64'h8000_0800);
    doUpdate(PC_J, 0, 0, 64'h0, 0, 0);
    applyStimulus("jalr_max", PC_J, 1, 1, 64'h8000_0800);

    // Mid-run asynchronous reset, and no training while it is held.
    @(negedge clk_i);
    #2;
    rst_i = 1'b1;
    applyStimulus("mid_reset", PC_J, 0, 0, 64'h8000_0024);
    checkOutput("cnt_mid_reset", {32'd0, mispredict_cnt_o}, 64'd0);
    doUpdate(PC_J, 1, 1, 64'h8000_0400, 1, 0);
    applyStimulus("upd_in_reset", PC_J, 0, 0, 64'h8000_0024);
    checkOutput("cnt_in_reset", {32'd0, mispredict_cnt_o}, 64'd0);
    @(negedge clk_i);
    rst_i = 1'b0;

    // Mispredict counting, including one alongside a flush.
    for (int i = 0; i < 5; i++) begin
      doUpdate(PC_N, 0, 0, 64'h0, 1, (i == 2));
    end
    for (int i = 0; i < 2; i++) begin
      doUpdate(PC_N, 0, 0, 64'h0, 0, 0);
    end
    @(negedge clk_i);
    upd_mispredict_i = 1'b1;
    @(posedge clk_i);
    #1;
    upd_mispredict_i = 1'b0;
    checkOutput("cnt_five", {32'd0, mispredict_cnt_o}, 64'd5);

    // PC wrap on a miss.
    applyStimulus("wrap", 64'hFFFF_FFFF_FFFF_FFFC, 0, 0, 64'h0);

    // Saturation: with the count held at all-ones, a mispredict must not wrap.
    force dut.miss_count = 32'hFFFF_FFFF;
    @(negedge clk_i);
    upd_valid_i = 1'b1; upd_pc_i = PC_N; upd_is_jump_i = 1'b0; upd_taken_i = 1'b0;
    upd_mispredict_i = 1'b1;
    #1;
    checkOutput("cnt_saturate", {32'd0, dut.miss_count_next}, 64'hFFFF_FFFF);
    @(posedge clk_i);
    #1;
    upd_valid_i = 1'b0; upd_mispredict_i = 1'b0;
    release dut.miss_count;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
